score_display_ctrl: RTL and testbench

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/sevenseg_pkg.sv | 6 +
 rtl/bin2bcd_seq.sv | 37 +++
 rtl/score_display_ctrl.sv | 91 +++++++++
 tb/tb_score_display_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared FSM encoding and display constants for the score display path
package sevenseg_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [6:0] MAX_SCORE = 7'd99;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative 7-bit binary to two-digit BCD converter, one shift-add-3 step per cycle
// Ports: clk, rst (sync active-low); start_i loads bin_i; done_o is high during the
//        last of the 7 iterations, so tens_o/ones_o hold the result from the next cycle on.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [6:0] bin_i,
  output logic       done_o,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);
  logic [14:0] sh_q, sh_d;
  logic [2:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  logic [3:0] t_adj, o_adj;
  assign done_o = busy_q & (cnt_q == 3'd6);
  assign tens_o = sh_q[14:11];
  assign ones_o = sh_q[10:7];
  always_comb begin
    t_adj = sh_q[14:11] >= 4'd5 ? sh_q[14:11] + 4'd3 : sh_q[14:11];
    o_adj = sh_q[10:7] >= 4'd5 ? sh_q[10:7] + 4'd3 : sh_q[10:7];
    sh_d = start_i ? {8'd0, bin_i} : busy_q ? {t_adj, o_adj, sh_q[6:0]} << 1 : sh_q;
    cnt_d = start_i ? 3'd0 : busy_q ? cnt_q + 3'd1 : cnt_q;
    busy_d = start_i | (busy_q & ~done_o);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      sh_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: accepts a score, converts it to BCD and drives a blinking two-digit display
// Ports: clk, rst (sync active-low); score/score_valid/score_ready input handshake;
//        scan_en one-clk multiplexer strobe; d3..d0 digit nibbles (4'hF = blank).
module score_display_ctrl
  import sevenseg_pkg::*;
#(
  parameter int SCAN_DIV = 25000,
  parameter int BLINK_HALF = 1000,
  parameter int BLINK_HALVES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] score,
  input  logic       score_valid,
  output logic       score_ready,
  output logic       scan_en,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int PW = BLINK_HALF > 1 ? $clog2(BLINK_HALF) : 1;
  localparam int HW = $clog2(BLINK_HALVES + 1);
  state_e state_q, state_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [PW-1:0] pcnt_q, pcnt_d, pcnt_b;
  logic [HW-1:0] half_q, half_d, half_b;
  logic [3:0] tens_q, tens_d, ones_q, ones_d, d1_q, d1_d, d0_q, d0_d, conv_tens, conv_ones;
  logic start, load, conv_done, blank, wrap, adv;
  logic [6:0] sat;
  bin2bcd_seq u_conv (
    .clk(clk),
    .rst(rst),
    .start_i(start),
    .bin_i(sat),
    .done_o(conv_done),
    .tens_o(conv_tens),
    .ones_o(conv_ones)
  );
  always_ff @(posedge clk) state_q <= rst ? state_d : IDLE;
  always_comb
    state_d = state_q == IDLE ? (score_valid ? CONV : IDLE) :
              state_q == CONV ? (conv_done ? DONE : CONV) : IDLE;
  always_comb begin
    score_ready = state_q == IDLE;
    start = score_ready & score_valid;
    load = state_q == DONE;
  end
  assign sat = score > MAX_SCORE ? MAX_SCORE : score;
  assign scan_en = scan_q == SW'(SCAN_DIV - 1);
  assign d3 = BLANK;
  assign d2 = BLANK;
  assign d1 = d1_q;
  assign d0 = d0_q;
  // A DONE restarts the blink from zero before any coincident scan pulse is counted,
  // so that pulse lands in the new sequence. Odd halves are the shown ones.
  always_comb begin
    scan_d = scan_en ? '0 : scan_q + SW'(1);
    half_b = load ? '0 : half_q;
    pcnt_b = load ? '0 : pcnt_q;
    wrap = pcnt_b == PW'(BLINK_HALF - 1);
    adv = scan_en & (half_b < HW'(BLINK_HALVES));
    pcnt_d = adv ? (wrap ? '0 : pcnt_b + PW'(1)) : pcnt_b;
    half_d = (adv & wrap) ? half_b + HW'(1) : half_b;
    blank = (half_q < HW'(BLINK_HALVES)) & ~half_q[0];
    tens_d = load ? conv_tens : tens_q;
    ones_d = load ? conv_ones : ones_q;
    // Fresh digits are shown unblanked for the first cycle after DONE; blanking follows.
    d1_d = load ? (conv_tens == 4'd0 ? BLANK : conv_tens) : ((blank | (tens_q == 4'd0)) ? BLANK : tens_q);
    d0_d = load ? conv_ones : (blank ? BLANK : ones_q);
  end
  always_ff @(posedge clk)
    if (!rst) begin
      scan_q <= '0;
      pcnt_q <= '0;
      half_q <= HW'(BLINK_HALVES);
      tens_q <= '0;
      ones_q <= '0;
      d1_q <= BLANK;
      d0_q <= '0;
    end else begin
      scan_q <= scan_d;
      pcnt_q <= pcnt_d;
      half_q <= half_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      d1_q <= d1_d;
      d0_q <= d0_d;
    end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: directed stimulus with a cycle model checked every cycle plus literal pins
module tb_score_display_ctrl;
  localparam int SD = 4;
  localparam int BH = 2;
  localparam int BN = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic score_valid = 1'b0;
  logic [6:0] score = '0;
  logic score_ready, scan_en;
  logic [3:0] d3, d2, d1, d0;
  int checks = 0;
  int errors = 0;
  logic seen55 = 1'b0;
  score_display_ctrl #(.SCAN_DIV(SD), .BLINK_HALF(BH), .BLINK_HALVES(BN)) dut (
    .clk(clk),
    .rst(rst),
    .score(score),
    .score_valid(score_valid),
    .score_ready(score_ready),
    .scan_en(scan_en),
    .d3(d3),
    .d2(d2),
    .d1(d1),
    .d0(d0)
  );
  always #5 clk = ~clk;
  // model: cycle count since reset, pending conversion, shown value, scan pulses since last update
  logic m_started = 1'b0;
  logic m_conv, m_blink_on;
  int m_cyc = 0, m_done_at = 0, m_pulses = 0, m_val = 0, m_pend = 0;
  logic [3:0] m_o1, m_o0;
  function automatic logic m_scan(int c);
    return (c % SD) == SD - 1;
  endfunction
  function automatic logic m_blank();
    return m_blink_on && m_pulses < BH * BN && ((m_pulses / BH) % 2) == 0;
  endfunction
  always @(posedge clk) begin
    if (!rst) begin
      m_started <= 1'b1;
      m_cyc <= 0;
      m_conv <= 1'b0;
      m_val <= 0;
      m_blink_on <= 1'b0;
      m_pulses <= 0;
      m_o1 <= 4'hF;
      m_o0 <= 4'h0;
    end else begin
      m_cyc <= m_cyc + 1;
      if (!m_conv && score_valid) begin
        m_conv <= 1'b1;
        m_pend <= score > 99 ? 99 : int'(score);
        m_done_at <= m_cyc + 8;
      end
      if (m_conv && m_cyc == m_done_at) begin
        m_conv <= 1'b0;
        m_val <= m_pend;
        m_blink_on <= 1'b1;
        m_pulses <= m_scan(m_cyc) ? 1 : 0;
        m_o1 <= (m_pend / 10 == 0) ? 4'hF : 4'(m_pend / 10);
        m_o0 <= 4'(m_pend % 10);
      end else begin
        if (m_scan(m_cyc)) m_pulses <= m_pulses + 1;
        m_o1 <= (m_blank() || m_val / 10 == 0) ? 4'hF : 4'(m_val / 10);
        m_o0 <= m_blank() ? 4'hF : 4'(m_val % 10);
      end
    end
  end
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, m_cyc, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (d1 == 4'd5 && d0 == 4'd5) seen55 <= 1'b1;
    if (m_started) begin
      chk("m_scan_en", {7'd0, scan_en}, {7'd0, m_scan(m_cyc)});
      chk("m_ready", {7'd0, score_ready}, {7'd0, !m_conv});
      chk("m_d1", {4'd0, d1}, {4'd0, m_o1});
      chk("m_d0", {4'd0, d0}, {4'd0, m_o0});
      chk("m_d3d2", {d3, d2}, 8'hFF);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go_to(input int n);
    int g = 0;
    while (m_cyc < n && g < 1000) begin
      step();
      g++;
    end
    chk("go_to", {7'd0, m_cyc == n}, 8'd1);
  endtask
  task automatic load(input int v);
    int n = 0;
    while (!score_ready && n < 50) begin
      step();
      n++;
    end
    chk("ready_before_load", {7'd0, score_ready}, 8'd1);
    score = 7'(v);
    score_valid = 1'b1;
    step();
    score_valid = 1'b0;
  endtask
  task automatic disp(input string name, input logic [3:0] e1, input logic [3:0] e0);
    chk(name, {d1, d0}, {e1, e0});
  endtask
  initial begin
    step();
    step();
    disp("reset_disp", 4'hF, 4'h0);
    chk("reset_ready", {7'd0, score_ready}, 8'd1);
    chk("reset_scan", {7'd0, scan_en}, 8'd0);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("prescale", {7'd0, scan_en}, {7'd0, k == 3 || k == 7 || k == 11});
      step();
    end
    load(42);
    for (int i = 0; i < 8; i++) begin
      chk("busy_ready", {7'd0, score_ready}, 8'd0);
      step();
    end
    chk("ready_back", {7'd0, score_ready}, 8'd1);
    disp("show_42", 4'd4, 4'd2);
    go_to(22);
    disp("blink_blank1", 4'hF, 4'hF);
    go_to(28);
    disp("blink_blank1_end", 4'hF, 4'hF);
    go_to(29);
    disp("blink_show1", 4'd4, 4'd2);
    go_to(37);
    disp("blink_blank2", 4'hF, 4'hF);
    go_to(45);
    disp("blink_show2", 4'd4, 4'd2);
    go_to(60);
    disp("steady_42", 4'd4, 4'd2);
    load(7);
    repeat (8) step();
    disp("show_7", 4'hF, 4'd7);
    load(120);
    repeat (8) step();
    disp("show_sat", 4'd9, 4'd9);
    load(0);
    repeat (8) step();
    disp("show_0", 4'hF, 4'd0);
    load(13);
    step();
    step();
    score = 7'd55;
    score_valid = 1'b1;
    repeat (3) step();
    score_valid = 1'b0;
    repeat (3) step();
    disp("show_13", 4'd1, 4'd3);
    step();
    disp("restart_blank", 4'hF, 4'hF);
    go_to(100);
    disp("coincident_blank", 4'hF, 4'hF);
    go_to(101);
    disp("coincident_show", 4'd1, 4'd3);
    go_to(110);
    load(88);
    step();
    step();
    rst = 1'b0;
    step();
    disp("rst_conv_disp", 4'hF, 4'h0);
    chk("rst_conv_ready", {7'd0, score_ready}, 8'd1);
    rst = 1'b1;
    load(88);
    repeat (8) step();
    disp("show_88", 4'd8, 4'd8);
    repeat (40) step();
    disp("steady_88", 4'd8, 4'd8);
    chk("never_55", {7'd0, seen55}, 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
